// File: rtl/mem_stage_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl_pkg
// Shared definitions for the MEM-stage controller:
//   - bit positions inside the 4-bit EX/MEM control field
//   - state encoding of the memory-access FSM
// -----------------------------------------------------------------------------
package mem_stage_ctrl_pkg;

  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_stage_ctrl_memwb.sv
// -----------------------------------------------------------------------------
// memwb_reg
// MEM/WB pipeline register with a bubble-insert input. When bubble is high the
// register loads an all-zero entry, so no write-back is triggered downstream.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   bubble              load a null entry instead of the *_in values
//   ctrl_in[1:0]        {RegWrite, MemtoReg}
//   alu_in, reg_dst_in  ALU result and destination register
//   read_data_in        load data
//   ctrl_WB, ALU_out_WB, reg_dst_WB, read_data_WB  registered outputs
// -----------------------------------------------------------------------------
module memwb_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble,
  input  logic [1:0]  ctrl_in,
  input  logic [31:0] alu_in,
  input  logic [4:0]  reg_dst_in,
  input  logic [31:0] read_data_in,
  output logic [1:0]  ctrl_WB,
  output logic [31:0] ALU_out_WB,
  output logic [4:0]  reg_dst_WB,
  output logic [31:0] read_data_WB
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      ctrl_WB      <= '0;
      ALU_out_WB   <= '0;
      reg_dst_WB   <= '0;
      read_data_WB <= '0;
    end else begin
      ctrl_WB      <= ctrl_in;
      ALU_out_WB   <= alu_in;
      reg_dst_WB   <= reg_dst_in;
      read_data_WB <= read_data_in;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// MEM-stage controller: turns the EX/MEM register contents into requests on a
// ready/valid data-memory port, stalls the front of the pipeline while an
// access is outstanding, and owns the MEM/WB register.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   ALU_out_MEM, write_data_MEM,
//   reg_dst_MEM, ctrl_MEM            EX/MEM register outputs
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_ready, mem_rdata  data-memory port
//   stall                            freezes PC, IF/ID, ID/EX, EX/MEM
//   read_data_WB, ALU_out_WB,
//   reg_dst_WB, ctrl_WB              MEM/WB register outputs
//   mem_err                          sticky error (timeout/misalign/R+W)
// -----------------------------------------------------------------------------
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALU_out_MEM,
  input  logic [31:0] write_data_MEM,
  input  logic [4:0]  reg_dst_MEM,
  input  logic [3:0]  ctrl_MEM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] read_data_WB,
  output logic [31:0] ALU_out_WB,
  output logic [4:0]  reg_dst_WB,
  output logic [1:0]  ctrl_WB,
  output logic        mem_err
);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [31:0]      rbuf, rbuf_next;
  logic             err_next;
  logic             bubble;
  logic [31:0]      wb_rdata;
  logic             mem_op, misaligned, rw_conflict;
  logic [31:0]      rdata_capture;

  // EX/MEM holds these stable while stall is high, so they drive the port
  // directly without an extra register stage.
  assign mem_we    = ctrl_MEM[CTRL_MEMWRITE];
  assign mem_addr  = ALU_out_MEM;
  assign mem_wdata = write_data_MEM;

  assign mem_op      = ctrl_MEM[CTRL_MEMREAD] | ctrl_MEM[CTRL_MEMWRITE];
  assign rw_conflict = ctrl_MEM[CTRL_MEMREAD] & ctrl_MEM[CTRL_MEMWRITE];
  assign misaligned  = |ALU_out_MEM[1:0];

  // Read data is only meaningful for reads; a store leaves an empty buffer.
  assign rdata_capture = mem_we ? '0 : mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rbuf    <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      rbuf    <= rbuf_next;
      mem_err <= err_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rbuf_next  = rbuf;
    err_next   = mem_err;
    mem_req    = 1'b0;
    stall      = 1'b0;
    bubble     = 1'b0;
    wb_rdata   = '0;

    case (state)
      IDLE: begin
        if (mem_op) begin
          if (rw_conflict) err_next = 1'b1;
          if (misaligned) begin
            // Dropped access: flag it and retire a bubble in one cycle.
            err_next = 1'b1;
            bubble   = 1'b1;
          end else begin
            mem_req = 1'b1;
            stall   = 1'b1;
            bubble  = 1'b1;
            if (mem_ready) begin
              rbuf_next  = rdata_capture;
              state_next = DONE;
              cnt_next   = '0;
            end else begin
              state_next = BUSY;
              cnt_next   = CNT_W'(1);
            end
          end
        end
      end

      BUSY: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        bubble  = 1'b1;
        if (mem_ready) begin
          rbuf_next  = rdata_capture;
          state_next = DONE;
          cnt_next   = '0;
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          rbuf_next  = '0;
          err_next   = 1'b1;
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      DONE: begin
        // EX/MEM advances at this edge together with the MEM/WB load.
        wb_rdata   = rbuf;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  memwb_reg u_memwb (
    .clk          (clk),
    .reset        (reset),
    .bubble       (bubble),
    .ctrl_in      (ctrl_MEM[CTRL_REGWRITE:CTRL_MEMTOREG]),
    .alu_in       (ALU_out_MEM),
    .reg_dst_in   (reg_dst_MEM),
    .read_data_in (wb_rdata),
    .ctrl_WB      (ctrl_WB),
    .ALU_out_WB   (ALU_out_WB),
    .reg_dst_WB   (reg_dst_WB),
    .read_data_WB (read_data_WB)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
// Scoreboard bench for mem_stage_ctrl: the expected MEM/WB entry of each
// operation is queued when the operation is driven and compared when the
// stage retires it (first edge with stall low).
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALU_out_MEM, write_data_MEM, mem_addr, mem_wdata, mem_rdata;
  logic [4:0]  reg_dst_MEM, reg_dst_WB;
  logic [3:0]  ctrl_MEM;
  logic        mem_req, mem_we, mem_ready, stall, mem_err;
  logic [31:0] read_data_WB, ALU_out_WB;
  logic [1:0]  ctrl_WB;

  typedef struct {
    logic [1:0]  ctrl;
    logic [31:0] alu;
    logic [4:0]  rdst;
    logic [31:0] rd;
    bit          full;   // 0: bubble entry, only ctrl_WB is defined
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_bad    = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .ALU_out_MEM    (ALU_out_MEM),
    .write_data_MEM (write_data_MEM),
    .reg_dst_MEM    (reg_dst_MEM),
    .ctrl_MEM       (ctrl_MEM),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .stall          (stall),
    .read_data_WB   (read_data_WB),
    .ALU_out_WB     (ALU_out_WB),
    .reg_dst_WB     (reg_dst_WB),
    .ctrl_WB        (ctrl_WB),
    .mem_err        (mem_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] c, input logic [31:0] a,
                          input logic [4:0] r, input logic [31:0] d, input bit full);
    exp_t e;
    e.ctrl = c; e.alu = a; e.rdst = r; e.rd = d; e.full = full;
    exp_q.push_back(e);
  endtask

  task automatic drive_nop();
    ctrl_MEM       = 4'b0000;
    ALU_out_MEM    = '0;
    write_data_MEM = '0;
    reg_dst_MEM    = '0;
    mem_ready      = 1'b0;
    mem_rdata      = '0;
  endtask

  task automatic check_wb_zero(input string tag);
    check({tag, "_ctrl"}, 32'(ctrl_WB), 32'd0);
    check({tag, "_alu"},  ALU_out_WB,   32'd0);
    check({tag, "_reg"},  32'(reg_dst_WB), 32'd0);
    check({tag, "_rd"},   read_data_WB, 32'd0);
  endtask

  // Called just after a rising edge. waits < 0 means mem_ready never rises.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rdst, input logic [31:0] rdata,
                        input int waits, input int exp_stall);
    int   k = 0, n_stall = 0, n_req = 0;
    bit   done = 0, st;
    exp_t e;
    ctrl_MEM = c; ALU_out_MEM = a; write_data_MEM = wd; reg_dst_MEM = rdst;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      st = stall;
      if (mem_req) begin
        n_req++;
        if (n_req == 1) begin
          check("port_we",    32'(mem_we), 32'(c[0]));
          check("port_addr",  mem_addr,    a);
          check("port_wdata", mem_wdata,   wd);
        end
        mem_ready = (waits >= 0) && (k == waits);
        k++;
      end else begin
        mem_ready = 1'b0;
      end
      mem_rdata = mem_ready ? rdata : 32'hFFFF_FFFF;
      if (st) n_stall++;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (st) begin
        check("bubble_ctrl", 32'(ctrl_WB), 32'd0);
      end else begin
        done = 1;
        if (exp_q.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wb_ctrl", 32'(ctrl_WB), 32'(e.ctrl));
          if (e.full) begin
            check("wb_alu",  ALU_out_WB,      e.alu);
            check("wb_reg",  32'(reg_dst_WB), 32'(e.rdst));
            check("wb_rd",   read_data_WB,    e.rd);
          end
        end
      end
    end
    if (!done) check("commit_bound", 32'd0, 32'd1);
    check("stall_cycles", 32'(n_stall), 32'(exp_stall));
    check("req_cycles",   32'(n_req),   32'(exp_stall));
    drive_nop();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_nop();
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    drive_nop();
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(stall),   32'd0);
    check("rst_req",   32'(mem_req), 32'd0);
    check("rst_err",   32'(mem_err), 32'd0);
    check_wb_zero("rst");
    reset = 1'b0;

    // R-type pass-through
    push_exp(2'b10, 32'h1234, 5'd5, 32'd0, 1);
    run_op(4'b1000, 32'h1234, 32'h0, 5'd5, 32'h0, 0, 0);

    // Load, zero wait
    push_exp(2'b11, 32'h40, 5'd7, 32'hDEAD_BEEF, 1);
    run_op(4'b1110, 32'h40, 32'h0, 5'd7, 32'hDEAD_BEEF, 0, 1);
    check("load0_err", 32'(mem_err), 32'd0);

    // Store, 3 wait cycles
    push_exp(2'b00, 32'h80, 5'd9, 32'd0, 1);
    run_op(4'b0001, 32'h80, 32'hA5A5_A5A5, 5'd9, 32'h0, 3, 4);
    check("store_err", 32'(mem_err), 32'd0);

    // Load, 2 wait cycles
    push_exp(2'b11, 32'h44, 5'd12, 32'h0BAD_F00D, 1);
    run_op(4'b1110, 32'h44, 32'h0, 5'd12, 32'h0BAD_F00D, 2, 3);

    // Misaligned load: dropped, bubble, error
    push_exp(2'b00, 32'h0, 5'd0, 32'd0, 0);
    run_op(4'b1110, 32'h41, 32'h0, 5'd4, 32'h1111_1111, 0, 0);
    check("misalign_err", 32'(mem_err), 32'd1);

    do_reset();
    check("reset_clears_err", 32'(mem_err), 32'd0);

    // Read and write both set: performed as a write, flagged
    push_exp(2'b10, 32'h60, 5'd6, 32'd0, 1);
    run_op(4'b1011, 32'h60, 32'h5555_AAAA, 5'd6, 32'h0, 0, 1);
    check("rw_err", 32'(mem_err), 32'd1);

    do_reset();

    // Timeout: ready never comes
    push_exp(2'b11, 32'h100, 5'd2, 32'd0, 1);
    run_op(4'b1110, 32'h100, 32'h0, 5'd2, 32'h0, -1, 16);
    check("timeout_err", 32'(mem_err), 32'd1);
    push_exp(2'b10, 32'h7, 5'd1, 32'd0, 1);
    run_op(4'b1000, 32'h7, 32'h0, 5'd1, 32'h0, 0, 0);
    check("err_sticky", 32'(mem_err), 32'd1);

    // Reset in BUSY cycle 2, then a late mem_ready
    ctrl_MEM = 4'b1110; ALU_out_MEM = 32'h200; reg_dst_MEM = 5'd3; mem_ready = 1'b0;
    @(posedge clk); #1;   // IDLE -> BUSY
    @(posedge clk); #1;   // now in BUSY cycle 2
    check("mid_stall_before", 32'(stall), 32'd1);
    reset = 1'b1;
    drive_nop();
    @(posedge clk); #1;
    check("mid_req",   32'(mem_req), 32'd0);
    check("mid_stall", 32'(stall),   32'd0);
    check("mid_err",   32'(mem_err), 32'd0);
    check_wb_zero("mid");
    reset = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    check("late_ready_req", 32'(mem_req), 32'd0);
    check("late_ready_rd",  read_data_WB, 32'd0);
    check("late_ready_err", 32'(mem_err), 32'd0);
    drive_nop();
    exp_q.delete();

    push_exp(2'b11, 32'h48, 5'd14, 32'h1357_9BDF, 1);
    run_op(4'b1110, 32'h48, 32'h0, 5'd14, 32'h1357_9BDF, 1, 2);
    check("final_err", 32'(mem_err), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage controller that consumes the EX/MEM pipeline register outputs (ALU_out_MEM, write_data_MEM, reg_dst_MEM, ctrl_MEM) and drives a ready/valid data-memory port.
- Holds the pipeline on `stall` while a memory access is outstanding, and writes the MEM/WB register it contains.
- Sits between the EX/MEM register and the write-back mux. It replaces the single-cycle combinational data memory with a variable-latency one.

Parameters:
- TIMEOUT, 15: maximum wait cycles for mem_ready before the access is aborted.
- CNT_W, 4: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- ALU_out_MEM  input  32  effective address / ALU result from EX/MEM
- write_data_MEM  input  32  store data from EX/MEM
- reg_dst_MEM  input  5  destination register from EX/MEM
- ctrl_MEM  input  4  control bits: [3] RegWrite, [2] MemtoReg, [1] MemRead, [0] MemWrite
- mem_req  output  1  memory request valid
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  32  word-aligned byte address
- mem_wdata  output  32  store data
- mem_ready  input  1  memory accepts/completes the request in this cycle
- mem_rdata  input  32  read data, valid when mem_req & mem_ready & !mem_we
- stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM
- read_data_WB  output  32  MEM/WB load data
- ALU_out_WB  output  32  MEM/WB ALU result
- reg_dst_WB  output  5  MEM/WB destination register
- ctrl_WB  output  2  MEM/WB control bits: [1] RegWrite, [0] MemtoReg
- mem_err  output  1  sticky error flag: timeout, misaligned access, or Read+Write both set

Behaviour:
- Reset: all MEM/WB outputs 0, mem_err 0, state IDLE, counter 0. mem_req and stall are 0 in the cycle following reset.
- A memory op is ctrl_MEM[1] | ctrl_MEM[0]. If both bits are set, the access is treated as a write and mem_err is set.
- mem_we = ctrl_MEM[0]. mem_addr = ALU_out_MEM. mem_wdata = write_data_MEM. These outputs are driven directly from the inputs, which EX/MEM holds stable while stall is high.
- FSM states IDLE, BUSY, DONE:
  - IDLE, no memory op: stall=0, mem_req=0. MEM/WB loads at the next edge with ctrl_WB = ctrl_MEM[3:2] and read_data_WB = 0 (latency 1).
  - IDLE, memory op, ALU_out_MEM[1:0] != 0 (misaligned): no request is issued. mem_err is set and a bubble (ctrl_WB = 0) is loaded. The op completes in 1 cycle with stall=0.
  - IDLE, aligned memory op: mem_req=1 and stall=1, both combinational. MEM/WB loads a bubble.
    - If mem_ready=1, mem_rdata is captured into an internal buffer and the FSM goes to DONE.
    - Otherwise the FSM goes to BUSY and the counter is set to 1.
  - BUSY: mem_req=1, stall=1, MEM/WB loads a bubble each cycle.
    - mem_ready=1: capture rdata, go to DONE, clear the counter.
    - counter == TIMEOUT: abort. The buffer is set to 0, mem_err is set, the FSM goes to DONE.
    - Otherwise the counter increments.
  - DONE: mem_req=0, stall=0. MEM/WB loads ctrl_MEM[3:2], ALU_out_MEM, reg_dst_MEM, and the buffer into read_data_WB. The FSM returns to IDLE (EX/MEM advances at the same edge).
- Stall cycles for an aligned access with ready arriving after N wait cycles: N+1. Total MEM occupancy: N+2.
- Bubble rule: while stall=1, ctrl_WB is forced to 0, so no duplicate write-back occurs.
- mem_err clears only on reset.
- Reset mid-access: the FSM returns to IDLE and mem_req drops at the next cycle. Any late mem_ready is ignored.
- mem_ready arriving while mem_req=0 is ignored.

Decomposition:
- Shared package: ctrl bit-index constants (CTRL_REGWRITE=3, CTRL_MEMTOREG=2, CTRL_MEMREAD=1, CTRL_MEMWRITE=0) and the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
- One natural sub-module, memwb_reg: the MEM/WB output register with a bubble-insert input, reusable by the single-cycle-memory variant.

Test Plan:
- R-type pass-through: ctrl_MEM=4'b1000, ALU_out_MEM=32'h1234, reg_dst_MEM=5 -> next cycle ctrl_WB=2'b10, ALU_out_WB=32'h1234, reg_dst_WB=5, stall never high.
- Load with zero wait: ctrl_MEM=4'b1110, addr 32'h40, mem_ready=1 in the same cycle, mem_rdata=32'hDEADBEEF -> stall high 1 cycle, then DONE; read_data_WB=32'hDEADBEEF, ctrl_WB=2'b11.
- Store with 3 wait cycles: ctrl_MEM=4'b0001, addr 32'h80, wdata 32'hA5A5A5A5 -> mem_req/mem_we high 4 cycles, stall high 4 cycles, bubble in WB for 4 cycles, ctrl_WB=2'b00 after DONE, mem_err=0.
- Timeout: load with mem_ready held low -> stall high TIMEOUT+1 = 16 cycles, then read_data_WB=0, mem_err=1 and stays 1 until reset.
- Misaligned load at addr 32'h41 -> mem_req never asserted, stall=0, ctrl_WB=2'b00, mem_err=1.
- Reset asserted in BUSY cycle 2 -> next cycle mem_req=0, stall=0, all WB outputs 0, mem_err=0; a subsequent load completes normally.
